// File: rtl/mem_write_checker.sv
// Watches core bus writes and compares them, in order, against a preloaded table of
// expected (address, data) pairs, raising a sticky pass or fail verdict.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | comparing bus writes against table[match_cnt]
// PASS  | all expected writes seen in order (sticky)
// FAIL  | mismatch or timeout, see fail_code (sticky)
module mem_write_checker #(
    parameter int DW       = 32,
    parameter int DEPTH    = 8,
    parameter int IGN_LO   = 96,
    parameter int IGN_HI   = 96,
    parameter int MAX_WAIT = 1024,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [IW-1:0] load_idx,
    input  logic [DW-1:0] load_adr,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] num_exp,
    input  logic          start,
    input  logic          mem_write,
    input  logic [DW-1:0] data_adr,
    input  logic [DW-1:0] write_data,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [CW-1:0] match_cnt,
    output logic [DW-1:0] fail_adr,
    output logic [DW-1:0] fail_data
);

    localparam int TW = $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0] IGN_LO_V = DW'(IGN_LO);
    localparam logic [DW-1:0] IGN_HI_V = DW'(IGN_HI);
    localparam logic [CW-1:0] DEPTH_V  = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST_V  = TW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] tab_adr  [DEPTH];
    logic [DW-1:0] tab_data [DEPTH];
    logic [CW-1:0] num_lat;
    logic [CW-1:0] num_sel;
    logic [TW-1:0] timer;
    logic [IW-1:0] ptr;
    logic          ign, wr_live, hit_adr, hit_data, match, timeout, last_match;

    // match_cnt doubles as the table pointer: entries are consumed strictly in order
    assign ptr        = IW'(match_cnt);
    assign num_sel    = (num_exp > DEPTH_V) ? DEPTH_V : num_exp;
    assign ign        = (data_adr >= IGN_LO_V) && (data_adr <= IGN_HI_V);
    assign wr_live    = mem_write && !ign;
    assign hit_adr    = (data_adr == tab_adr[ptr]);
    assign hit_data   = (write_data == tab_data[ptr]);
    assign match      = wr_live && hit_adr && hit_data;
    assign timeout    = (timer == TLAST_V);
    assign last_match = ((match_cnt + CW'(1)) == num_lat);

    always_ff @(posedge clk) begin
        if (load_en && state != S_RUN) begin
            tab_adr[load_idx]  <= load_adr;
            tab_data[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN: begin
                if (match) begin
                    if (last_match) state_nx = S_PASS;
                end else if (wr_live || timeout) begin
                    state_nx = S_FAIL;
                end
            end
            default: begin
                if (start) state_nx = (num_sel == '0) ? S_PASS : S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_lat   <= '0;
            match_cnt <= '0;
            timer     <= '0;
            fail_code <= 2'd0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else if (state != S_RUN) begin
            if (start) begin
                num_lat   <= num_sel;
                match_cnt <= '0;
                timer     <= '0;
                fail_code <= 2'd0;
                fail_adr  <= '0;
                fail_data <= '0;
            end
        end else if (match) begin
            match_cnt <= match_cnt + CW'(1);
            timer     <= '0;
        end else if (wr_live) begin
            fail_code <= hit_adr ? 2'd2 : 2'd1;
            fail_adr  <= data_adr;
            fail_data <= write_data;
        end else begin
            // ignored-range writes fall through here: they neither clear nor pause the timer
            timer <= timer + TW'(1);
            if (timeout) fail_code <= 2'd3;
        end
    end

    assign busy = (state == S_RUN);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: table load, in-order matching, mismatch and
// timeout verdicts, clamping, start/load gating in RUN and asynchronous reset.
module tb_mem_write_checker;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int IW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [DW-1:0] load_adr, load_data;
    logic [CW-1:0] num_exp;
    logic          start, mem_write;
    logic [DW-1:0] data_adr, write_data;
    logic          busy, pass, fail;
    logic [1:0]    fail_code;
    logic [CW-1:0] match_cnt;
    logic [DW-1:0] fail_adr, fail_data;

    int checks = 0;
    int failures = 0;

    mem_write_checker #(
        .DW(DW), .DEPTH(DEPTH), .IGN_LO(96), .IGN_HI(96), .MAX_WAIT(16)
    ) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_adr(load_adr), .load_data(load_data), .num_exp(num_exp),
        .start(start), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .busy(busy), .pass(pass), .fail(fail),
        .fail_code(fail_code), .match_cnt(match_cnt), .fail_adr(fail_adr),
        .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input int adr, input int dat);
        load_en = 1'b1; load_idx = IW'(idx); load_adr = DW'(adr); load_data = DW'(dat);
        tick();
        load_en = 1'b0;
    endtask

    task automatic go(input int n);
        start = 1'b1; num_exp = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int adr, input int dat);
        mem_write = 1'b1; data_adr = DW'(adr); write_data = DW'(dat);
        tick();
        mem_write = 1'b0;
    endtask

    task automatic chk_verdict(input string tag, input logic b, input logic p, input logic f,
                               input int code);
        chk({tag, "_busy"}, 64'(busy), 64'(b));
        chk({tag, "_pass"}, 64'(pass), 64'(p));
        chk({tag, "_fail"}, 64'(fail), 64'(f));
        chk({tag, "_code"}, 64'(fail_code), 64'(code));
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; load_idx = '0; load_adr = '0; load_data = '0;
        num_exp = '0; start = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
        tick(); tick();
        chk_verdict("rst", 1'b0, 1'b0, 1'b0, 0);
        chk("rst_cnt", 64'(match_cnt), 0);
        chk("rst_fadr", 64'(fail_adr), 0);
        reset = 1'b1;
        tick();

        // single expected write, scratch writes ignored, write with start ignored
        load(0, 100, 25);
        mem_write = 1'b1; data_adr = 100; write_data = 25;
        go(1);
        mem_write = 1'b0;
        chk("s_busy", 64'(busy), 1);
        chk("s_cnt", 64'(match_cnt), 0);
        wr(96, 7);
        wr(96, 9);
        chk("ign_busy", 64'(busy), 1);
        wr(100, 25);
        chk_verdict("pass1", 1'b0, 1'b1, 1'b0, 0);
        chk("pass1_cnt", 64'(match_cnt), 1);
        wr(104, 3);
        chk_verdict("pass_sticky", 1'b0, 1'b1, 1'b0, 0);

        // address mismatch
        go(1);
        chk("restart_pass", 64'(pass), 0);
        wr(104, 25);
        chk_verdict("adr_mm", 1'b0, 1'b0, 1'b1, 1);
        chk("adr_mm_fadr", 64'(fail_adr), 104);
        chk("adr_mm_fdata", 64'(fail_data), 25);

        // data mismatch
        go(1);
        chk("restart_code", 64'(fail_code), 0);
        chk("restart_fadr", 64'(fail_adr), 0);
        wr(100, 24);
        chk_verdict("dat_mm", 1'b0, 1'b0, 1'b1, 2);
        chk("dat_mm_fadr", 64'(fail_adr), 100);
        chk("dat_mm_fdata", 64'(fail_data), 24);

        // timeout: verdict visible 16 edges after the start edge
        go(1);
        for (int i = 1; i <= 15; i++) begin
            mem_write = (i % 2 == 1); data_adr = 96; write_data = DW'(i);
            tick();
        end
        mem_write = 1'b0;
        chk_verdict("pre_to", 1'b1, 1'b0, 1'b0, 0);
        tick();
        chk_verdict("to", 1'b0, 1'b0, 1'b1, 3);
        chk("to_fadr", 64'(fail_adr), 0);
        chk("to_fdata", 64'(fail_data), 0);

        // four-entry table, with a long gap (timer must restart on each match)
        load(0, 100, 1); load(1, 104, 2); load(2, 108, 3); load(3, 112, 4);
        go(4);
        wr(100, 1);
        chk("m4_cnt1", 64'(match_cnt), 1);
        go(1);
        chk("run_start_busy", 64'(busy), 1);
        chk("run_start_cnt", 64'(match_cnt), 1);
        wr(104, 2);
        chk("m4_cnt2", 64'(match_cnt), 2);
        for (int i = 0; i < 12; i++) tick();
        chk("gap_busy", 64'(busy), 1);
        wr(108, 3);
        chk("m4_cnt3", 64'(match_cnt), 3);
        wr(112, 4);
        chk("m4_cnt4", 64'(match_cnt), 4);
        chk_verdict("m4", 1'b0, 1'b1, 1'b0, 0);

        // num_exp above DEPTH clamps to DEPTH
        go(7);
        wr(100, 1); wr(104, 2); wr(108, 3);
        chk("clamp_busy", 64'(busy), 1);
        wr(112, 4);
        chk("clamp_cnt", 64'(match_cnt), 4);
        chk("clamp_pass", 64'(pass), 1);

        // num_exp = 0 passes immediately
        go(0);
        chk_verdict("zero", 1'b0, 1'b1, 1'b0, 0);
        chk("zero_cnt", 64'(match_cnt), 0);

        // load during RUN ignored, then asynchronous reset mid-run
        go(1);
        load(0, 200, 200);
        reset = 1'b0;
        #1;
        chk_verdict("arst", 1'b0, 1'b0, 1'b0, 0);
        tick();
        reset = 1'b1;
        tick();
        chk_verdict("post_rst", 1'b0, 1'b0, 1'b0, 0);
        chk("post_rst_cnt", 64'(match_cnt), 0);
        wr(100, 1);
        chk("idle_ign", 64'(busy), 0);
        go(1);
        wr(100, 1);
        chk_verdict("tab_kept", 1'b0, 1'b1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter DW, default 32: width of data_adr, write_data, load_adr, load_data.
REQ-002 Parameter DEPTH, default 8: expected-write table entries; IW = clog2(DEPTH), CW = clog2(DEPTH+1).
REQ-003 Parameter IGN_LO, default 96: lowest ignored (scratch) write address.
REQ-004 Parameter IGN_HI, default 96: highest ignored write address, inclusive; IGN_HI >= IGN_LO.
REQ-005 Parameter MAX_WAIT, default 1024: timeout in cycles since the last event; >= 2.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 load_en  in  1  write load_adr/load_data into table[load_idx].
REQ-009 load_idx  in  IW  table index for load.
REQ-010 load_adr, load_data  in  DW each  expected address/data.
REQ-011 num_exp  in  CW  expected-write count, sampled on start; values > DEPTH clamp to DEPTH.
REQ-012 start  in  1  begin a check run.
REQ-013 mem_write  in  1  bus write strobe from core.
REQ-014 data_adr, write_data  in  DW each  bus write address/data.
REQ-015 busy  out  1  high in RUN.
REQ-016 pass, fail  out  1 each  sticky verdicts.
REQ-017 fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout.
REQ-018 match_cnt  out  CW  matched writes this run.
REQ-019 fail_adr, fail_data  out  DW each  offending write captured on failure (0 on timeout).

Function
REQ-020 States IDLE, RUN, PASS, FAIL; bus sampled at rising edge when mem_write=1.
REQ-021 load_en accepted in IDLE, PASS, FAIL; ignored in RUN; table not cleared by reset or start.
REQ-022 start in any state except RUN: latch num_exp, clear match_cnt, pointer, timer, fail_code, fail_adr, fail_data, pass, fail; next state RUN, or PASS if latched num_exp = 0.
REQ-023 start while in RUN: ignored.
REQ-024 mem_write in the same cycle as an accepted start: ignored.
REQ-025 RUN, write with IGN_LO <= data_adr <= IGN_HI: ignored; no pointer or timer change.
REQ-026 RUN, non-ignored write equal to table[ptr] in address and data: ptr, match_cnt +1, timer cleared; if new match_cnt = latched num_exp -> PASS.
REQ-027 RUN, non-ignored write with data_adr != table[ptr].adr -> FAIL, code 1; address equal but write_data differs -> FAIL, code 2; fail_adr/fail_data capture the write.
REQ-028 RUN, timer increments each cycle without a matching write; reaching MAX_WAIT -> FAIL, code 3; a match in the terminating cycle takes priority.
REQ-029 Verdict latency: pass/fail/busy reflect the decision one cycle after the deciding sample edge.
REQ-030 PASS and FAIL are sticky; leave only by start or reset; bus writes there are ignored.
REQ-031 match_cnt saturates at latched num_exp; never wraps.

Reset
REQ-032 reset low asynchronously forces IDLE, busy=0, pass=0, fail=0, fail_code=0, match_cnt=0, fail_adr=0, fail_data=0, timer=0, pointer=0.
REQ-033 reset asserted mid-RUN abandons the run with no verdict; after release, module waits for start.

Verification
REQ-034 Table[0]=(100,25), num_exp=1, start; writes (96,7),(96,9),(100,25) -> pass=1 one cycle after third write, match_cnt=1, fail_code=0.
REQ-035 Same table; write (104,25) -> fail=1, fail_code=1, fail_adr=104, fail_data=25.
REQ-036 Same table; write (100,24) -> fail=1, fail_code=2, fail_data=24.
REQ-037 MAX_WAIT=16, num_exp=1, only writes to 96 -> fail_code=3 exactly 16 cycles after start accepted.
REQ-038 DEPTH=4, table (100,1),(104,2),(108,3),(112,4), num_exp=4, in-order writes -> match_cnt 1..4, pass=1; num_exp=0 -> pass=1 one cycle after start.
REQ-039 reset low two cycles after start, then high -> all outputs 0, IDLE; load_en during RUN leaves table unchanged.
